// File: rtl/desired_drive_pkg.sv
// Shared types and widths for the sequential desired-drive datapath.
package desired_drive_pkg;

  localparam int TORQUE_W   = 12;
  localparam int INCL_LIM_W = 9;
  localparam int CAD_F_W    = 6;
  localparam int PROD_W     = 29;

  localparam logic [TORQUE_W-1:0] TORQUE_MIN_DEF = 12'h380;

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    MUL2,
    MUL3,
    SAT
  } dd_state_e;

endpackage

// File: rtl/desired_drive_seq_if.sv
// Start/busy/done handshake and operand/result bus of the desired-drive engine.
interface desired_drive_seq_if;
  logic        start;
  logic [11:0] avg_torque;
  logic [4:0]  cadence_vec;
  logic [12:0] incline;
  logic [1:0]  setting;
  logic        busy;
  logic        done;
  logic [11:0] target_curr;

  modport master (
    output start, avg_torque, cadence_vec, incline, setting,
    input  busy, done, target_curr
  );

  modport slave (
    input  start, avg_torque, cadence_vec, incline, setting,
    output busy, done, target_curr
  );
endinterface

// File: rtl/dd_shared_mult.sv
// Shared unsigned 27x9 multiplier; the product is kept to the 29 bits the datapath needs.
module dd_shared_mult (
  input  logic [26:0] i_a,
  input  logic [8:0]  i_b,
  output logic [28:0] o_p
);
  assign o_p = 29'(i_a) * 29'(i_b);
endmodule

// File: rtl/desired_drive_seq.sv
// Desired-drive target current, one shared multiplier stepped over MUL1..MUL3.
// Optional DESIRED_DRIVE_ZERO_SKIP_EN shortcuts zero-operand requests to a 2-cycle result.
module desired_drive_seq
  import desired_drive_pkg::*;
#(
  parameter logic [TORQUE_W-1:0] TORQUE_MIN = TORQUE_MIN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  desired_drive_seq_if.slave dd
);

  dd_state_e               r_state, w_next;
  logic [TORQUE_W-1:0]     r_torque, r_tc;
  logic [INCL_LIM_W-1:0]   r_incl;
  logic [CAD_F_W-1:0]      r_cad;
  logic [1:0]              r_set;
  logic [PROD_W-1:0]       r_prod, w_prod;
  logic                    r_done;
  logic [26:0]             w_mul_a;
  logic [8:0]              w_mul_b;
  logic [TORQUE_W-1:0]     w_torque_pos;
  logic [INCL_LIM_W-1:0]   w_incl_lim;
  logic [CAD_F_W-1:0]      w_cad_f;
  logic signed [13:0]      w_incl_ofs;

  // Saturating to [-512,511] before the +256 offset is subsumed by the final [0,511] clamp.
  assign w_torque_pos = (dd.avg_torque < TORQUE_MIN) ? '0 : dd.avg_torque - TORQUE_MIN;
  assign w_incl_ofs   = $signed({dd.incline[12], dd.incline}) + 14'sd256;
  assign w_incl_lim   = w_incl_ofs[13] ? '0 :
                        (w_incl_ofs > 14'sd511) ? 9'h1FF : w_incl_ofs[8:0];
  assign w_cad_f      = (dd.cadence_vec > 5'd1) ? ({1'b0, dd.cadence_vec} + 6'd32) : '0;

`ifdef DESIRED_DRIVE_ZERO_SKIP_EN
  logic r_skip;
  logic w_zero;
  assign w_zero = (w_torque_pos == '0) | (w_incl_lim == '0) |
                  (w_cad_f == '0) | (dd.setting == 2'd0);
`endif

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      MUL1: begin
        w_mul_a = {15'd0, r_torque};
        w_mul_b = r_incl;
      end
      MUL2: begin
        w_mul_a = r_prod[26:0];
        w_mul_b = {3'd0, r_cad};
      end
      MUL3: begin
        w_mul_a = r_prod[26:0];
        w_mul_b = {7'd0, r_set};
      end
      default: ;
    endcase
  end

  dd_shared_mult u_mult (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (dd.start) begin
`ifdef DESIRED_DRIVE_ZERO_SKIP_EN
        // Zero requests pass through MUL3 with the product cleared, giving the 2-cycle result.
        w_next = w_zero ? MUL3 : MUL1;
`else
        w_next = MUL1;
`endif
      end
      MUL1:    w_next = MUL2;
      MUL2:    w_next = MUL3;
      MUL3:    w_next = SAT;
      SAT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_torque <= '0;
      r_incl   <= '0;
      r_cad    <= '0;
      r_set    <= '0;
      r_prod   <= '0;
      r_tc     <= '0;
      r_done   <= 1'b0;
`ifdef DESIRED_DRIVE_ZERO_SKIP_EN
      r_skip   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: if (dd.start) begin
          r_torque <= w_torque_pos;
          r_incl   <= w_incl_lim;
          r_cad    <= w_cad_f;
          r_set    <= dd.setting;
`ifdef DESIRED_DRIVE_ZERO_SKIP_EN
          r_skip   <= w_zero;
          if (w_zero) r_prod <= '0;
`endif
        end
        MUL1: r_prod <= w_prod;
        MUL2: r_prod <= w_prod;
`ifdef DESIRED_DRIVE_ZERO_SKIP_EN
        MUL3: r_prod <= r_skip ? '0 : w_prod;
`else
        MUL3: r_prod <= w_prod;
`endif
        SAT: begin
          r_tc   <= (|r_prod[28:26]) ? 12'hFFF : r_prod[25:14];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dd.busy        = (r_state != IDLE);
  assign dd.done        = r_done;
  assign dd.target_curr = r_tc;

endmodule

// File: tb/tb_desired_drive_seq.sv
// Directed bench for desired_drive_seq with a cycle-level result/latency model.
module tb_desired_drive_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  desired_drive_seq_if dd();

  desired_drive_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dd    (dd)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Product of the four scaled operands in plain integer arithmetic.
  function automatic longint model_prod(input logic [11:0] tq, input logic [4:0] cad,
                                        input logic [12:0] inc, input logic [1:0] st);
    longint tp, il, cf, iv;
    tp = (tq < 12'h380) ? 0 : longint'(tq) - 'h380;
    iv = longint'($signed(inc));
    if (iv > 511)  iv = 511;
    if (iv < -512) iv = -512;
    il = iv + 256;
    if (il < 0)   il = 0;
    if (il > 511) il = 511;
    cf = (cad > 1) ? longint'(cad) + 32 : 0;
    return tp * il * cf * longint'(st);
  endfunction

  function automatic logic [11:0] model_out(input longint p);
    if (p >= (longint'(1) << 26)) return 12'hFFF;
    return 12'((p >> 14) % 4096);
  endfunction

  function automatic int model_lat(input longint p);
`ifdef DESIRED_DRIVE_ZERO_SKIP_EN
    return (p == 0) ? 2 : 4;
`else
    return (p == 0) ? 4 : 4;
`endif
  endfunction

  int          m_cnt;
  logic        m_done;
  logic [11:0] m_tc, m_pend;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_tc   <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else if (m_cnt == 1) begin
        m_cnt  <= 0;
        m_done <= 1'b1;
        m_tc   <= m_pend;
      end else if (dd.start) begin
        m_pend <= model_out(model_prod(dd.avg_torque, dd.cadence_vec, dd.incline, dd.setting));
        m_cnt  <= model_lat(model_prod(dd.avg_torque, dd.cadence_vec, dd.incline, dd.setting));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", dd.busy, m_cnt > 0);
      chk("done", dd.done, m_done);
      chk("target_curr", dd.target_curr, m_tc);
    end
  end

  task automatic set_ops(input logic [11:0] tq, input logic [4:0] cad,
                         input logic [12:0] inc, input logic [1:0] st);
    dd.avg_torque  = tq;
    dd.cadence_vec = cad;
    dd.incline     = inc;
    dd.setting     = st;
  endtask

  task automatic go(input logic [11:0] tq, input logic [4:0] cad,
                    input logic [12:0] inc, input logic [1:0] st);
    set_ops(tq, cad, inc, st);
    dd.start = 1'b1;
    @(negedge clk);
    dd.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!dd.done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (!dd.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input string nm, input logic [11:0] tq, input logic [4:0] cad,
                     input logic [12:0] inc, input logic [1:0] st,
                     input logic [11:0] exp_tc, input int exp_lat);
    int lat;
    chk({nm, "_model"}, model_out(model_prod(tq, cad, inc, st)), exp_tc);
    go(tq, cad, inc, st);
    wait_done(lat);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_tc"}, dd.target_curr, exp_tc);
    @(negedge clk);
  endtask

`ifdef DESIRED_DRIVE_ZERO_SKIP_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 4;
`endif

  initial begin
    int lat;
    rst_n    = 1'b0;
    dd.start = 1'b0;
    set_ops('0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_busy", dd.busy, 1'b0);
    chk("rst_done", dd.done, 1'b0);
    chk("rst_tc", dd.target_curr, 12'h000);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run("basic",    12'h800, 5'h10, 13'h0150, 2'd2, 12'hD79, 4);
    run("neg_incl", 12'h800, 5'h10, 13'h1F22, 2'd3, 12'h158, 4);
    run("low_tq",   12'h360, 5'h10, 13'h0150, 2'd3, 12'h000, ZLAT);
    run("low_cad",  12'h800, 5'h01, 13'h0150, 2'd3, 12'h000, ZLAT);
    run("ovf",      12'hFFF, 5'h1F, 13'h0150, 2'd3, 12'hFFF, 4);
    run("min_tq",   12'h381, 5'h10, 13'h00FF, 2'd2, 12'h002, 4);
    run("incl_min", 12'h800, 5'h10, 13'h1000, 2'd3, 12'h000, ZLAT);
    run("set_off",  12'h800, 5'h10, 13'h0150, 2'd0, 12'h000, ZLAT);

    // Re-pulse during MUL2 with new operands, then back-to-back start in the done cycle.
    go(12'h800, 5'h10, 13'h0150, 2'd2);
    set_ops(12'hFFF, 5'h1F, 13'h0150, 2'd3);
    @(negedge clk);
    dd.start = 1'b1;
    @(negedge clk);
    dd.start = 1'b0;
    wait_done(lat);
    chk("repulse_lat", lat, 2);
    chk("repulse_tc", dd.target_curr, 12'hD79);
    go(12'h800, 5'h10, 13'h1F22, 2'd3);
    wait_done(lat);
    chk("b2b_lat", lat, 4);
    chk("b2b_tc", dd.target_curr, 12'h158);
    @(negedge clk);

    // Reset in MUL2 aborts the computation.
    go(12'h800, 5'h10, 13'h0150, 2'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", dd.busy, 1'b0);
    chk("midrst_done", dd.done, 1'b0);
    chk("midrst_tc", dd.target_curr, 12'h000);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_nodone", dd.done, 1'b0);
    end
    run("post_rst", 12'h800, 5'h10, 13'h0150, 2'd2, 12'hD79, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
